// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: memory-bus types shared by ram_responder and memory_control
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef logic [31:0] word_t;
  typedef logic [29:0] word_addr_t;
endpackage

// File: rtl/ram_responder_if.sv
// ram_responder_if: requester/responder bus plus the preload port
interface ram_responder_if;
  import cpu_types_pkg::*;
  logic ramREN, ramWEN, ldWEN;
  word_t ramaddr, ramstore, ramload, ldaddr, lddata;
  ramstate_t ramstate;
  modport master (output ramREN, ramWEN, ramaddr, ramstore, ldWEN, ldaddr, lddata,
                  input ramload, ramstate);
  modport slave (input ramREN, ramWEN, ramaddr, ramstore, ldWEN, ldaddr, lddata,
                 output ramload, ramstate);
endinterface

// File: rtl/ram_responder_lat_counter.sv
// ram_lat_counter: counts cycles a request is held unchanged; restarts on address/op change
module ram_lat_counter import cpu_types_pkg::*; #(
  parameter int LAT = 2
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  req,
  input  logic  op,
  input  word_t addr,
  output logic  at_lat
);
  logic [3:0] cnt_q, cnt_d, ecnt;
  word_t last_addr_q, last_addr_d;
  logic last_op_q, last_op_d, last_vld_q, last_vld_d;
  always_comb begin
    ecnt = (req && last_vld_q && addr == last_addr_q && op == last_op_q) ? cnt_q : '0;
    at_lat = req && ecnt == 4'(LAT);
    last_vld_d = req && !at_lat;
    cnt_d = last_vld_d ? ecnt + 4'd1 : '0;
    last_addr_d = last_vld_d ? addr : last_addr_q;
    last_op_d = last_vld_d ? op : last_op_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      last_addr_q <= '0;
      last_op_q <= 1'b0;
      last_vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      last_addr_q <= last_addr_d;
      last_op_q <= last_op_d;
      last_vld_q <= last_vld_d;
    end
  end
endmodule

// File: rtl/ram_responder.sv
// ram_responder: fixed-latency word RAM model answering a level-held REN/WEN requester
module ram_responder import cpu_types_pkg::*; #(
  parameter int LAT   = 2,
  parameter int WORDS = 256
) (
  input logic CLK,
  input logic RST,
  ram_responder_if.slave bus
);
  localparam int AW = $clog2(WORDS);
  logic req, op, err, valid_req, at_lat, ld_ok, wr_en, ld_unused;
  logic [AW-1:0] windex, lindex, wr_idx;
  word_t wr_data;
  word_t mem_q [WORDS];
  assign ld_unused = ^bus.ldaddr[1:0];
  ram_lat_counter #(.LAT(LAT)) u_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .req    (valid_req),
    .op     (op),
    .addr   (bus.ramaddr),
    .at_lat (at_lat)
  );
  // Out-of-range accesses error out rather than aliasing onto low words
  always_comb begin
    req = bus.ramREN ^ bus.ramWEN;
    op = bus.ramWEN;
    windex = bus.ramaddr[2 +: AW];
    lindex = bus.ldaddr[2 +: AW];
    err = (bus.ramREN & bus.ramWEN) | (req & |(bus.ramaddr >> (AW + 2)));
    valid_req = req & !err;
    bus.ramstate = RST ? FREE : err ? ERROR : !req ? FREE : at_lat ? ACCESS : BUSY;
    bus.ramload = (bus.ramstate == ACCESS && !op) ? mem_q[windex] : '0;
    ld_ok = bus.ldWEN && !req && bus.ramstate != ERROR && !(|(bus.ldaddr >> (AW + 2)));
    wr_en = (bus.ramstate == ACCESS && op) || ld_ok;
    wr_idx = ld_ok ? lindex : windex;
    wr_data = ld_ok ? bus.lddata : bus.ramstore;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed + random stimulus, reference model feeding a per-cycle scoreboard
module tb_ram_responder;
  import cpu_types_pkg::*;
  localparam int LAT = 2;
  localparam int WORDS = 256;
  typedef struct packed { ramstate_t s; word_t l; } exp_t;

  logic clk = 1'b0;
  logic rst;
  ram_responder_if bus();
  ram_responder #(.LAT(LAT), .WORDS(WORDS)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;

  exp_t q[$];
  exp_t me;
  int errors = 0, checks = 0, t = 0, mon_cyc = 0;
  string phase = "init";
  word_t mem_m [WORDS];
  logic kv = 1'b0, ko = 1'b0;
  word_t ka = '0;
  int t0 = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      checks += 2;
      if (bus.ramstate !== me.s) begin
        errors++;
        $display("FAIL %s cyc=%0d ramstate got %0d want %0d", phase, mon_cyc, bus.ramstate, me.s);
      end
      if (bus.ramload !== me.l) begin
        errors++;
        $display("FAIL %s cyc=%0d ramload got %h want %h", phase, mon_cyc, bus.ramload, me.l);
      end
      mon_cyc++;
    end
  end

  // An access started at cycle t0 on a fixed (addr, op) completes at t0+LAT
  task automatic cyc(input logic r, ren, wen, input word_t a, st, input logic lw, input word_t la, ld);
    exp_t e;
    int idx;
    rst = r;
    bus.ramREN = ren;
    bus.ramWEN = wen;
    bus.ramaddr = a;
    bus.ramstore = st;
    bus.ldWEN = lw;
    bus.ldaddr = la;
    bus.lddata = ld;
    e.l = '0;
    idx = int'(a[31:2]);
    if (r) begin
      e.s = FREE;
      kv = 1'b0;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (ren && wen) begin
      e.s = ERROR;
      kv = 1'b0;
    end else if (ren || wen) begin
      if (idx >= WORDS) begin
        e.s = ERROR;
        kv = 1'b0;
      end else begin
        if (!(kv && ka == a && ko == wen)) begin
          kv = 1'b1; ka = a; ko = wen; t0 = t;
        end
        if (t - t0 == LAT) begin
          e.s = ACCESS;
          kv = 1'b0;
          if (wen) mem_m[idx] = st;
          else e.l = mem_m[idx];
        end else e.s = BUSY;
      end
    end else begin
      e.s = FREE;
      kv = 1'b0;
      if (lw && int'(la[31:2]) < WORDS) mem_m[int'(la[31:2])] = ld;
    end
    q.push_back(e);
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, '0, '0, 0, '0, '0);
  endtask
  task automatic rd(input word_t a, input int n);
    repeat (n) cyc(0, 1, 0, a, word_t'($urandom), 0, '0, '0);
  endtask
  task automatic wr(input word_t a, d, input int n);
    repeat (n) cyc(0, 0, 1, a, d, 0, '0, '0);
  endtask
  task automatic pre(input word_t a, d);
    cyc(0, 0, 0, '0, '0, 1, a, d);
  endtask

  logic ren_r = 1'b0, wen_r = 1'b0, lw_r = 1'b0;
  word_t a_r = '0, la_r = '0, ld_r = '0;
  int sel;

  initial begin
    rst = 1'b1;
    bus.ramREN = 1'b0; bus.ramWEN = 1'b0; bus.ramaddr = '0; bus.ramstore = '0;
    bus.ldWEN = 1'b0; bus.ldaddr = '0; bus.lddata = '0;
    @(posedge clk);
    #1;
    phase = "reset";
    repeat (2) cyc(1, 1, 0, 32'h40, '0, 0, '0, '0);
    phase = "preload_read";
    pre(32'h40, 32'hDEADBEEF); rd(32'h40, 3); idle(1);
    phase = "write_read";
    wr(32'h80, 32'h12345678, 3); rd(32'h80, 3); idle(1);
    phase = "block";
    pre(32'h100, 32'hA1A1A1A1); pre(32'h104, 32'hB2B2B2B2);
    rd(32'h100, 3); rd(32'h104, 3); idle(1);
    phase = "restart";
    pre(32'h44, 32'h44444444); rd(32'h40, 1); rd(32'h44, 3); idle(1);
    phase = "held";
    rd(32'h80, 6); idle(1);
    phase = "error";
    repeat (3) cyc(0, 1, 1, 32'h40, 32'h0BAD0BAD, 1, 32'h40, 32'h0BAD0BAD);
    rd(32'h40, 3); rd(32'h400, 2); wr(32'h400, 32'h1, 2); idle(1);
    phase = "preload_blocked";
    repeat (3) cyc(0, 1, 0, 32'h48, '0, 1, 32'h48, 32'h99);
    pre(32'h800, 32'h77); rd(32'h48, 3); idle(1);
    phase = "reset_mid";
    wr(32'h20, 32'h55, 1);
    cyc(1, 0, 1, 32'h20, 32'h55, 0, '0, '0);
    rd(32'h20, 3); wr(32'h20, 32'h55, 3); rd(32'h20, 3); rd(32'h40, 3); idle(1);
    phase = "random";
    repeat (3000) begin
      if ($urandom_range(0, 9) == 0) begin
        sel = int'($urandom_range(0, 9));
        ren_r = (sel >= 3 && sel <= 5) || sel == 9;
        wen_r = (sel >= 6);
        a_r = ($urandom_range(0, 19) == 0) ? (32'($urandom_range(256, 2000)) << 2)
                                           : (32'($urandom_range(0, 15)) << 2);
        lw_r = $urandom_range(0, 2) == 0;
        la_r = ($urandom_range(0, 9) == 0) ? 32'h1000 : (32'($urandom_range(0, 15)) << 2);
        ld_r = $urandom;
      end
      cyc($urandom_range(0, 299) == 0, ren_r, wen_r, a_r, word_t'($urandom), lw_r, la_r, ld_r);
    end
    idle(1);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
